// File: rtl/ahb_pkg.sv
// Shared AHB encodings and default-subordinate state constants
// for the single-manager decoder/mux fabric slice.
package ahb_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'd0,
    TR_BUSY   = 2'd1,
    TR_NONSEQ = 2'd2,
    TR_SEQ    = 2'd3
  } trans_t;

  typedef enum logic [1:0] {
    RS_OKAY  = 2'd0,
    RS_ERROR = 2'd1
  } resp_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } def_state_t;

  localparam logic [1:0] AHB_TRANS_IDLE   = 2'd0;
  localparam logic [1:0] AHB_TRANS_BUSY   = 2'd1;
  localparam logic [1:0] AHB_TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] AHB_TRANS_SEQ    = 2'd3;

  localparam logic [1:0] AHB_RESP_OKAY  = 2'd0;
  localparam logic [1:0] AHB_RESP_ERROR = 2'd1;

  localparam logic [1:0] DEF_IDLE = 2'd0;
  localparam logic [1:0] DEF_ERR1 = 2'd1;
  localparam logic [1:0] DEF_ERR2 = 2'd2;

  function automatic logic ahb_active(input logic [1:0] tr);
    return (tr == AHB_TRANS_NONSEQ) || (tr == AHB_TRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_sub.sv
// Built-in default subordinate: two-cycle ERROR response for
// active transfers that decode to no mapped region.
module ahb_default_sub
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       nReset,
  input  logic       ready,
  input  logic       active,
  input  logic       hit,
  output logic       defReady,
  output logic [1:0] defResp
);

  logic [1:0] state_q, state_d;
  logic       take;

  assign take = ready & active & ~hit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DEF_IDLE: state_d = take ? DEF_ERR1 : DEF_IDLE;
      DEF_ERR1: state_d = DEF_ERR2;
      DEF_ERR2: state_d = take ? DEF_ERR1 : DEF_IDLE;
      default:  state_d = DEF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) state_q <= DEF_IDLE;
    else         state_q <= state_d;
  end

  assign defReady = (state_q != DEF_ERR1);
  assign defResp  = (state_q == DEF_IDLE) ? AHB_RESP_OKAY
                                          : AHB_RESP_ERROR;

endmodule

// File: rtl/ahb_sub_mux.sv
// Single-manager AHB decoder and response mux for NumSubs subordinates.
// Optional AHB_SECURE_CHECK_EN blocks non-secure access to secure regions.
module ahb_sub_mux
  import ahb_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int NumSubs   = 4,
  parameter logic [NumSubs*AddrWidth-1:0] BaseAddr = '0,
  parameter logic [NumSubs*AddrWidth-1:0] AddrMask = '0
`ifdef AHB_SECURE_CHECK_EN
  ,
  parameter logic [NumSubs-1:0] SecureRegion = '0
`endif
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic [AddrWidth-1:0]           addr,
  input  logic [1:0]                     trans,
  input  logic                           nonSec,
  output logic [NumSubs-1:0]             sel,
  output logic                           ready,
  input  logic [NumSubs-1:0]             subReadyOut,
  input  logic [2*NumSubs-1:0]           subResp,
  input  logic [DataWidth*NumSubs-1:0]   subRData,
  input  logic [NumSubs-1:0]             subExOkay,
  output logic [1:0]                     resp,
  output logic [DataWidth-1:0]           rData,
  output logic                           exOkay
);

  logic               active;
  logic [NumSubs-1:0] hit_raw;
  logic [NumSubs-1:0] sel_pri;
  logic [NumSubs:0]   dsel_q, dsel_d;
  logic               def_ready;
  logic [1:0]         def_resp;

  assign active = ahb_active(trans);

  always_comb begin
    hit_raw = '0;
    for (int i = 0; i < NumSubs; i++) begin
      hit_raw[i] =
        ((addr & AddrMask[i*AddrWidth +: AddrWidth])
          == BaseAddr[i*AddrWidth +: AddrWidth]);
    end
  end

  // Walk downward so the lowest hitting index is the last written.
  always_comb begin
    sel_pri = '0;
    for (int i = NumSubs - 1; i >= 0; i--) begin
      if (hit_raw[i]) begin
        sel_pri    = '0;
        sel_pri[i] = 1'b1;
      end
    end
  end

`ifdef AHB_SECURE_CHECK_EN
  logic blocked;
  assign blocked = active & nonSec & (|(sel_pri & SecureRegion));
  assign sel     = blocked ? '0 : sel_pri;
`else
  logic unused_nonsec;
  assign unused_nonsec = nonSec;
  assign sel           = sel_pri;
`endif

  assign dsel_d = ready ? {~(|sel), sel} : dsel_q;

  always_ff @(posedge clk) begin
    if (!nReset) dsel_q <= {1'b1, {NumSubs{1'b0}}};
    else         dsel_q <= dsel_d;
  end

  ahb_default_sub u_def (
    .clk      (clk),
    .nReset   (nReset),
    .ready    (ready),
    .active   (active),
    .hit      (|sel),
    .defReady (def_ready),
    .defResp  (def_resp)
  );

  always_comb begin
    ready  = dsel_q[NumSubs] & def_ready;
    resp   = dsel_q[NumSubs] ? def_resp : AHB_RESP_OKAY;
    rData  = '0;
    exOkay = 1'b0;
    for (int i = 0; i < NumSubs; i++) begin
      if (dsel_q[i]) begin
        ready  = ready | subReadyOut[i];
        resp   = resp | subResp[2*i +: 2];
        rData  = rData | subRData[i*DataWidth +: DataWidth];
        exOkay = exOkay | subExOkay[i];
      end
    end
  end

endmodule
